axi_lite_to_apb_bridge: RTL
===========================

// Module: axi_lite_to_apb_bridge
// PURPOSE
// - AXI4-Lite slave to single APB4 master bridge. Sits directly downstream of the AXI4+ATOP to AXI4-Lite converter.
// - Serialises reads and writes into one APB transfer at a time (no address decode, one PSEL).
// - Returns OKAY/SLVERR on B/R from PSLVERR.
// PARAMETERS
// - AddrWidth       32     width of AXI-Lite and APB address
// - DataWidth       32     data width; must be 8, 16 or 32 (APB4 limit)
// - axi_lite_req_t  logic  AXI-Lite request struct (aw/w/ar channels, valids, b_ready, r_ready)
// - axi_lite_rsp_t  logic  AXI-Lite response struct (readies, b/r channels, valids)
// PORTS
// - clk_i       in   1            clock, all state on rising edge
// - rst_ni      in   1            reset, synchronous, active-low
// - slv_req_i   in   req_t        AXI-Lite requests
// - slv_resp_o  out  rsp_t        AXI-Lite responses
// - paddr_o     out  AddrWidth    APB address
// - pprot_o     out  3            APB protection, copied from ax.prot
// - psel_o      out  1            APB select
// - penable_o   out  1            APB enable
// - pwrite_o    out  1            1 = write transfer
// - pwdata_o    out  DataWidth    write data
// - pstrb_o     out  DataWidth/8  write strobes; all-zero for reads
// - pready_i    in   1            APB ready
// - prdata_i    in   DataWidth    APB read data
// - pslverr_i   in   1            APB error
// BEHAVIOUR
// - FSM states:
//   - IDLE:   psel=0, penable=0
//   - SETUP:  psel=1, penable=0; always exactly one cycle
//   - ACCESS: psel=1, penable=1; held until pready_i=1
// - IDLE -> SETUP on an accepted request; SETUP -> ACCESS; ACCESS -> IDLE when pready_i=1.
// - IDLE always lasts >= 1 cycle between transfers.
// - Accepting a write, IDLE only:
//   - requires aw_valid & w_valid & B slot empty;
//   - aw_ready and w_ready assert together, combinationally, only in that cycle.
// - Accepting a read, IDLE only: requires ar_valid & R slot empty; ar_ready asserts combinationally.
// - Arbitration when both are eligible: round-robin on a last_was_write flag.
//   - Reset value 1, so the first conflict grants the read.
//   - Flag updates on every grant.
// - On the accept edge: addr, prot, wdata, strb and direction register into the APB outputs.
//   They stay stable through SETUP and ACCESS.
//   - Read: pstrb_o=0, pwdata_o=0.
// - Completion edge (ACCESS & pready_i):
//   - write: B slot loads resp; b_valid=1.
//   - read: R slot loads prdata_i and resp; r_valid=1.
//   - resp = pslverr_i ? 2'b10 (SLVERR) : 2'b00 (OKAY). pslverr_i is sampled only at this edge.
// - B/R slots are 1-deep.
//   - b_valid/r_valid hold, with stable payload, until b_ready/r_ready.
//   - Slot clears on the handshake edge.
// - Blocking rules:
//   - A full B slot blocks new writes only; reads proceed.
//   - A full R slot blocks new reads only.
//   - A slot drained in cycle t enables acceptance from cycle t+1 (no same-cycle bypass).
// - Minimum latency, with pready_i=1 in the first ACCESS cycle:
//   - accept at t, SETUP t+1, ACCESS t+2, b_valid/r_valid at t+3.
//   - Back-to-back throughput: 1 transfer per 4 cycles.
// - pready_i held low: bridge stays in ACCESS indefinitely. There is no timeout; all AXI readies stay 0.
// - Reset (rst_ni=0 sampled at an edge):
//   - FSM -> IDLE; slots empty; last_was_write=1.
//   - All APB outputs 0; all AXI readies/valids 0; data outputs 0.
//   - A transfer in flight at reset is dropped. psel_o deasserts at that edge, mid-ACCESS included.
// - Unused AXI-Lite response fields are driven 0.
// STRUCTURE
// - Response encodings come from axi_pkg (RESP_OKAY, RESP_SLVERR); no new package content.
// - State enum is local to the module.
// - Single flat module, no sub-module. Slots are plain registers, not spill registers, to keep them 1-deep and bypass-free.
// TESTING
// - Single write: AW addr=0x10, W data=0xCAFE_F00D, strb=0xF; pready=1 in ACCESS.
//   -> SETUP at t+1; ACCESS with pwrite=1, paddr=0x10; b_valid at t+3, resp=OKAY.
// - Read with wait states: AR addr=0x24; pready low for 3 ACCESS cycles; prdata=0x1234_5678, pslverr=1.
//   -> r_valid at t+6, r.data=0x12345678, resp=SLVERR; pstrb=0 throughout.
// - Simultaneous AR+AW in IDLE after reset.
//   -> read granted first, then write.
//   -> a second simultaneous pair grants write first (round-robin).
// - Backpressure: b_ready=0 with B full, then new AW+W plus AR.
//   -> write stalls (aw_ready=0) while the read completes.
//   -> write is accepted the cycle after b_ready handshake.
// - AW valid without W valid for 5 cycles.
//   -> no ready, psel stays 0; acceptance on the first cycle W is also valid.
// - rst_ni=0 during ACCESS with pready=0.
//   -> next edge: psel=penable=0, no b_valid/r_valid.
//   -> a new request after reset completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI-Lite response encodings and the 32-bit AXI-Lite channel structs
// shared by the APB bridge and its bench.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_lite_r_t r;
        logic        r_valid;
    } axi_lite_rsp_t;

endpackage

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI4-Lite slave to single APB4 master bridge. One APB transfer at a time,
// round-robin between reads and writes, 1-deep bypass-free B and R slots.
//
// state  | meaning
// IDLE   | no transfer; requests may be accepted here only
// SETUP  | psel=1, penable=0, exactly one cycle
// ACCESS | psel=1, penable=1, held until pready_i
module axi_lite_to_apb_bridge
    import axi_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter type axi_lite_req_t = axi_pkg::axi_lite_req_t,
    parameter type axi_lite_rsp_t = axi_pkg::axi_lite_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  axi_lite_req_t          slv_req_i,
    output axi_lite_rsp_t          slv_resp_o,
    output logic [AddrWidth-1:0]   paddr_o,
    output logic [2:0]             pprot_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_was_write_q;
    logic [AddrWidth-1:0]   paddr_q;
    logic [2:0]             pprot_q;
    logic                   pwrite_q;
    logic [DataWidth-1:0]   pwdata_q;
    logic [DataWidth/8-1:0] pstrb_q;
    logic                   b_valid_q;
    logic [1:0]             b_resp_q;
    logic                   r_valid_q;
    logic [DataWidth-1:0]   r_data_q;
    logic [1:0]             r_resp_q;

    logic wr_elig, rd_elig, grant_wr, grant_rd, done;

    // Eligibility, round-robin grant and next state; grants are gated by
    // reset so no ready can leak out while rst_ni is low.
    always_comb begin
        state_d  = state_q;
        wr_elig  = rst_ni && (state_q == IDLE) && slv_req_i.aw_valid
                   && slv_req_i.w_valid && !b_valid_q;
        rd_elig  = rst_ni && (state_q == IDLE) && slv_req_i.ar_valid && !r_valid_q;
        grant_wr = wr_elig && (!rd_elig || !last_was_write_q);
        grant_rd = rd_elig && (!wr_elig || last_was_write_q);
        done     = (state_q == ACCESS) && pready_i;
        case (state_q)
            IDLE:    if (grant_wr || grant_rd) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and arbitration history.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            last_was_write_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_wr)      last_was_write_q <= 1'b1;
            else if (grant_rd) last_was_write_q <= 1'b0;
        end
    end

    // Capture the granted request into the APB outputs; held until the next grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            paddr_q  <= '0;
            pprot_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (grant_wr) begin
            paddr_q  <= slv_req_i.aw.addr[AddrWidth-1:0];
            pprot_q  <= slv_req_i.aw.prot;
            pwrite_q <= 1'b1;
            pwdata_q <= slv_req_i.w.data[DataWidth-1:0];
            pstrb_q  <= slv_req_i.w.strb[DataWidth/8-1:0];
        end else if (grant_rd) begin
            paddr_q  <= slv_req_i.ar.addr[AddrWidth-1:0];
            pprot_q  <= slv_req_i.ar.prot;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end
    end

    // Response slots: drain on handshake, fill on APB completion. A slot is
    // never full at completion because acceptance required it empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
        end else begin
            if (b_valid_q && slv_req_i.b_ready) b_valid_q <= 1'b0;
            if (r_valid_q && slv_req_i.r_ready) r_valid_q <= 1'b0;
            if (done && pwrite_q) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
            end
            if (done && !pwrite_q) begin
                r_valid_q <= 1'b1;
                r_data_q  <= prdata_i;
                r_resp_q  <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // AXI-Lite response assembly; unused fields stay zero.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = grant_wr;
        slv_resp_o.w_ready  = grant_wr;
        slv_resp_o.ar_ready = grant_rd;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.r_valid  = r_valid_q;
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_resp_q;
    end

    assign psel_o    = (state_q != IDLE);
    assign penable_o = (state_q == ACCESS);
    assign paddr_o   = paddr_q;
    assign pprot_o   = pprot_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;

endmodule
